// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer (99..00) with 1 Hz prescaler, load/start/pause FSM and 2-digit display scan.
// Optional macro LEADING_ZERO_BLANK_EN darkens the tens digit while it is zero.
module bcd_down_timer #(
  parameter int TICK_DIV  = 100000000,
  parameter int SCAN_DIV  = 100000,
  parameter int INIT_TENS = 5,
  parameter int INIT_ONES = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic       done,
  output logic [3:0] led_ctrl,
  output logic [3:0] ssd_ctrl,
  output logic [7:0] ssd
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0] RST_TENS = 4'(INIT_TENS);
  localparam logic [3:0] RST_ONES = 4'(INIT_ONES);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t        state, state_next;
  logic [3:0]    tens, ones, tens_next, ones_next;
  logic [TW-1:0] tick_cnt, tick_next;
  logic [SW-1:0] scan_cnt;
  logic          scan_sel;
  logic [3:0]    load_tens, load_ones;
  logic          done_d;
  logic [3:0]    led_d, ctrl_d;
  logic [7:0]    ssd_d;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'b00000011;
      4'd1:    seg7 = 8'b10011111;
      4'd2:    seg7 = 8'b00100101;
      4'd3:    seg7 = 8'b00001101;
      4'd4:    seg7 = 8'b10011001;
      4'd5:    seg7 = 8'b01001001;
      4'd6:    seg7 = 8'b01000001;
      4'd7:    seg7 = 8'b00011111;
      4'd8:    seg7 = 8'b00000001;
      4'd9:    seg7 = 8'b00001001;
      default: seg7 = 8'b11111111;
    endcase
  endfunction

  assign load_tens = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
  assign load_ones = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tens     <= RST_TENS;
      ones     <= RST_ONES;
      tick_cnt <= '0;
    end else begin
      state    <= state_next;
      tens     <= tens_next;
      ones     <= ones_next;
      tick_cnt <= tick_next;
    end
  end

  // Tick counting is suppressed on the edge that pauses, so the held count resumes intact.
  always_comb begin
    state_next = state;
    tens_next  = tens;
    ones_next  = ones;
    tick_next  = tick_cnt;
    if (load) begin
      state_next = IDLE;
      tens_next  = load_tens;
      ones_next  = load_ones;
      tick_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (tens == 4'd0 && ones == 4'd0) begin
              state_next = DONE;
            end else begin
              state_next = RUN;
              tick_next  = '0;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (tens == 4'd0 && ones == 4'd0) begin
            state_next = DONE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_next = '0;
            if (ones != 4'd0) begin
              ones_next = ones - 4'd1;
            end else begin
              ones_next = 4'd9;
              tens_next = tens - 4'd1;
            end
            if (tens == 4'd0 && ones == 4'd1) state_next = DONE;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
        PAUSED: begin
          if (start || pause) state_next = RUN;
        end
        DONE: begin
          state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    done_d = (state == DONE);
    led_d  = (state == DONE) ? 4'b1111 : ones;
    if (scan_sel) begin
      ctrl_d = 4'b1101;
      ssd_d  = seg7(tens);
`ifdef LEADING_ZERO_BLANK_EN
      if (tens == 4'd0) begin
        ctrl_d = 4'b1111;
        ssd_d  = 8'b11111111;
      end
`endif
    end else begin
      ctrl_d = 4'b1110;
      ssd_d  = seg7(ones);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_sel <= 1'b0;
      done     <= 1'b0;
      led_ctrl <= 4'd0;
      ssd_ctrl <= 4'b1111;
      ssd      <= 8'b11111111;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_sel <= ~scan_sel;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      done     <= done_d;
      led_ctrl <= led_d;
      ssd_ctrl <= ctrl_d;
      ssd      <= ssd_d;
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: directed test-plan steps plus random pulses, checked every cycle against a value-level model.
module tb_bcd_down_timer;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       done;
  logic [3:0] led_ctrl, ssd_ctrl;
  logic [7:0] ssd;

  int checks = 0;
  int errors = 0;

  int m_state, m_val, m_tick, m_cyc;
  logic       e_done;
  logic [3:0] e_led, e_ctrl;
  logic [7:0] e_ssd;
  logic [7:0] seg_tab [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                               8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};

  bcd_down_timer #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .INIT_TENS(5), .INIT_ONES(9)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .pause(pause),
    .done(done), .led_ctrl(led_ctrl), .ssd_ctrl(ssd_ctrl), .ssd(ssd)
  );

  always #5 clk = ~clk;

  // Model works on the decimal value 0..99; outputs reflect the pre-edge value.
  task automatic model_update(input logic r, ld, input logic [7:0] lv, input logic st, pa);
    int sel, dig, t, o;
    if (r) begin
      m_state = M_IDLE; m_val = 59; m_tick = 0; m_cyc = 0;
      e_done = 1'b0; e_led = 4'd0; e_ctrl = 4'b1111; e_ssd = 8'hFF;
    end else begin
      sel = (m_cyc / SCAN_DIV) % 2;
      dig = sel ? m_val / 10 : m_val % 10;
      e_ctrl = sel ? 4'b1101 : 4'b1110;
      e_ssd  = seg_tab[dig];
`ifdef LEADING_ZERO_BLANK_EN
      if (sel == 1 && m_val < 10) begin
        e_ctrl = 4'b1111;
        e_ssd  = 8'hFF;
      end
`endif
      e_done = (m_state == M_DONE);
      e_led  = (m_state == M_DONE) ? 4'hF : 4'(m_val % 10);
      m_cyc++;
      if (ld) begin
        t = (lv[7:4] > 9) ? 9 : int'(lv[7:4]);
        o = (lv[3:0] > 9) ? 9 : int'(lv[3:0]);
        m_val = t * 10 + o; m_state = M_IDLE; m_tick = 0;
      end else begin
        case (m_state)
          M_IDLE: if (st) begin
            if (m_val == 0) m_state = M_DONE;
            else begin m_state = M_RUN; m_tick = 0; end
          end
          M_RUN: if (pa) m_state = M_PAUSED;
          else begin
            m_tick++;
            if (m_tick == TICK_DIV) begin
              m_tick = 0;
              m_val--;
              if (m_val == 0) m_state = M_DONE;
            end
          end
          M_PAUSED: if (st || pa) m_state = M_RUN;
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (done === e_done) else begin errors++; $error("FAIL done: got %0b expected %0b", done, e_done); end
    checks++;
    assert (led_ctrl === e_led) else begin errors++; $error("FAIL led_ctrl: got %b expected %b", led_ctrl, e_led); end
    checks++;
    assert (ssd_ctrl === e_ctrl) else begin errors++; $error("FAIL ssd_ctrl: got %b expected %b", ssd_ctrl, e_ctrl); end
    checks++;
    assert (ssd === e_ssd) else begin errors++; $error("FAIL ssd: got %b expected %b", ssd, e_ssd); end
  endtask

  task automatic step(input logic r, ld, input logic [7:0] lv, input logic st, pa);
    rst = r; load = ld; load_val = lv; start = st; pause = pa;
    @(posedge clk);
    model_update(r, ld, lv, st, pa);
    #1;
    check_outputs();
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and idle display scan
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(8);
    // Count 10 down to 00
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(44);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    // Pause/resume keeps the tick phase
    step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(20);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(16);
    // Clamp, zero start, ignored inputs in DONE
    step(1'b0, 1'b1, 8'hFA, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(3);
    // Reset mid-run at 42
    step(1'b0, 1'b1, 8'h43, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    idle(6);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(12);
    // Tens digit zero, load ignores start/pause in the same cycle
    step(1'b0, 1'b1, 8'h07, 1'b1, 1'b1);
    idle(6);
    // Random pulses
    for (int i = 0; i < 600; i++) begin
      logic       r, ld, st, pa;
      logic [7:0] lv;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 9) == 0);
      pa = ($urandom_range(0, 13) == 0);
      lv = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      step(r, ld, lv, st, pa);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Two-digit BCD countdown timer (99..00) driving the on-board 4-digit seven-segment display and LEDs.
- It is the down-counting counterpart of the existing BCD up counter.
- Has its own 1 Hz tick prescaler and 2-digit display scan, plus a load/start/pause control FSM and a done flag.
- Sits at board top level between the debounced pushbutton pulses and the display/LED pins.

Parameters:
- TICK_DIV, 100000000, clk cycles per count tick (1 Hz at 100 MHz); legal range ≥2.
- SCAN_DIV, 100000, clk cycles per display digit switch; legal range ≥1.
- INIT_TENS, 5, tens digit after reset (0-9).
- INIT_ONES, 9, ones digit after reset (0-9).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- load  input  1  single-cycle pulse: load load_val
- load_val  input  8  {tens[7:4], ones[3:0]} BCD; any nibble >9 is clamped to 9
- start  input  1  single-cycle pulse: start/resume counting
- pause  input  1  single-cycle pulse: toggle RUN/PAUSED
- done  output  1  high while in DONE
- led_ctrl  output  4  ones digit (4'b1111 in DONE)
- ssd_ctrl  output  4  digit enables, active-low; 4'b1110 = ones, 4'b1101 = tens
- ssd  output  8  segments {a,b,c,d,e,f,g,dp}, active-low, dp always 1

Behaviour:
- Reset (rst=1 at a clk edge):
  - Internal: state=IDLE, tens=INIT_TENS, ones=INIT_ONES, tick_cnt=0, scan_cnt=0, scan_sel=0 (ones).
  - Outputs: done=0, led_ctrl=4'd0, ssd_ctrl=4'b1111, ssd=8'b11111111.
  - Reset mid-count aborts immediately.
- Priority: rst > load > start/pause.
- load, in any state:
  - tens/ones <= clamped load_val.
  - state <= IDLE, tick_cnt <= 0.
  - start/pause in the same cycle are ignored.
- FSM states: IDLE, RUN, PAUSED, DONE.
  - IDLE + start, value≠00 -> RUN, tick_cnt<=0.
  - IDLE + start, value==00 -> DONE.
  - IDLE + pause -> no effect.
  - RUN + pause -> PAUSED; tick_cnt is held, not cleared.
  - PAUSED + pause or start -> RUN; tick_cnt resumes from its held value.
  - DONE: start and pause are ignored; leave only via load or rst.
  - RUN with start and pause in the same cycle -> pause wins (PAUSED).
- Tick (RUN only):
  - tick_cnt counts 0..TICK_DIV-1.
  - At TICK_DIV-1, tick_cnt wraps to 0 and the value decrements once.
- Decrement rule:
  - ones≠0 -> ones-1.
  - ones==0 -> ones=9, tens-1.
  - Never below 00; digits are always 0-9.
- Reaching 00: the decrement that yields 00 moves state to DONE on the same edge.
  - done rises one cycle after the value registers show 00.
- Display scan:
  - scan_cnt is free-running, independent of state, counts 0..SCAN_DIV-1.
  - scan_sel toggles on wrap.
- Display output registers:
  - ssd_ctrl/ssd are registered from scan_sel and the current digits, one-cycle latency.
  - First valid digit appears on the cycle after reset deasserts.
- Segment encodings:
  - Digits: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001.
  - Any other code -> 11111111.
- led_ctrl and done are registered: led_ctrl = ones, or 4'b1111 while in DONE.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when tens==0 and the tens digit is selected, ssd=8'b11111111 and ssd_ctrl=4'b1111 (digit dark). Scan timing is unchanged.
- Undefined: the tens digit always shows its value, including 0 (8'b00000011).

Test Plan:
- Params TICK_DIV=4, SCAN_DIV=2. Hold rst 2 cycles, release. Expect:
  - ssd_ctrl=1110, ssd=00001001 ('9') on the first cycle after release.
  - Digit then alternates with 1101 / 01001001 ('5') every 2 cycles.
  - done=0, led_ctrl=9.
- load_val=8'h10, then start. Expect:
  - After 4 clks the value becomes 09 (tens 0, ones 9), led_ctrl=9.
  - After 36 more clks the value is 00, state DONE, done=1, led_ctrl=1111.
- load 8'h03, start, run 2 clks, pause, wait 20 clks, pause. Expect:
  - Value stays 03 throughout the pause.
  - First decrement to 02 occurs exactly 2 clks after resume.
- load 8'hFA -> value 99. load 8'h00 then start -> DONE next cycle, done=1. Start again in DONE -> no change.
- Mid-RUN at value 42, assert rst one cycle. Expect:
  - Value 59, IDLE, done=0, ssd_ctrl=1111 on that edge.
  - Next tick is not taken until start.
- With LEADING_ZERO_BLANK_EN and value 07, tens slot shows ssd_ctrl=1111, ssd=11111111. Without the macro it shows 1101 / 00000011.
